load_store_unit: RTL

//  Initiator side of the data-memory interface. Accepts one load/store per handshake from
//  the core, drives the word-addressed data memory (address/write_data/memread/memwrite),
//  and performs byte/half/word access with sign/zero extension. Sub-word stores are done
//  as read-modify-write because the memory has no byte enables. Sits between EX and memory.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Data-memory initiator. Takes one load/store per handshake and
//            drives a word-addressed memory. Byte/half stores use
//            read-modify-write because the memory has no byte enables.
//            Load results are sign- or zero-extended.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int DEPTH       = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [29:0] C_DEPTH_IDX = 30'(DEPTH);
  localparam logic [1:0]  C_LAT_LAST  = 2'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        req_err;
  logic [29:0] word_idx;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] load_result;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

  // Request validation, lane extraction for loads and lane merge for stores.
  always_comb begin
    req_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
              (req_addr[31:2] >= C_DEPTH_IDX);
    // The address is taken straight from the port on the accept edge.
    word_idx = (state_q == IDLE) ? req_addr[31:2] : addr_q[31:2];
    // A legal half has addr[0]=0, so 8*addr[1:0] equals 16*addr[1].
    shamt    = {addr_q[1:0], 3'b000};
    shifted  = mem_read_data >> shamt;
    case (size_q)
      2'b00:   load_result = unsigned_q ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_result = unsigned_q ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: load_result = mem_read_data;
    endcase
    lane_mask   = (size_q == 2'b00) ? (32'h0000_00FF << shamt)
                                    : (32'h0000_FFFF << shamt);
    merged_word = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  // Next-state logic; every output is derived from the state being entered.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    write_d          = write_q;
    size_d           = size_q;
    unsigned_d       = unsigned_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    resp_rdata_d     = 32'd0;
    resp_err_d       = 1'b0;
    mem_write_data_d = mem_write_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          cnt_d      = 2'd0;
          if (req_err) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_write && req_size == 2'b10) begin
            state_d          = WR;
            mem_write_data_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == C_LAT_LAST) begin
          if (write_q) begin
            state_d          = WR;
            mem_write_data_d = merged_word;
          end else begin
            state_d      = RESP;
            resp_rdata_d = load_result;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
    req_ready_d   = (state_d == IDLE);
    resp_valid_d  = (state_d == RESP);
    mem_read_d    = (state_d == RD);
    mem_write_d   = (state_d == WR);
    mem_address_d = (mem_read_d || mem_write_d) ? {2'b00, word_idx} : 32'd0;
    if (!mem_write_d) begin
      mem_write_data_d = 32'd0;
    end
  end

  // State, latched request and registered outputs; reset aborts any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= 2'd0;
      write_q          <= 1'b0;
      size_q           <= 2'b00;
      unsigned_q       <= 1'b0;
      addr_q           <= 32'd0;
      wdata_q          <= 32'd0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'd0;
      resp_err_q       <= 1'b0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      write_q          <= write_d;
      size_q           <= size_d;
      unsigned_q       <= unsigned_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_err_q       <= resp_err_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
    end
  end

endmodule
`default_nettype wire
